mc_main_ctrl: RTL



---
 rtl/mips_ctrl_pkg.sv | 68 ++++++
 rtl/mc_out_decode.sv | 80 ++++++++
 rtl/mc_main_ctrl.sv | 116 +++++++++++
 3 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared constants, state encoding and control-word layout for the
// multicycle MIPS main control unit.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] ALUSRCB_B       = 2'b00;
  localparam logic [1:0] ALUSRCB_FOUR    = 2'b01;
  localparam logic [1:0] ALUSRCB_IMM     = 2'b10;
  localparam logic [1:0] ALUSRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    ST_INIT   = 4'd0,
    ST_FETCH  = 4'd1,
    ST_DECODE = 4'd2,
    ST_MEMADR = 4'd3,
    ST_MEMRD  = 4'd4,
    ST_MEMWB  = 4'd5,
    ST_MEMWR  = 4'd6,
    ST_EXEC   = 4'd7,
    ST_ALUWB  = 4'd8,
    ST_ADDIEX = 4'd9,
    ST_ADDIWB = 4'd10,
    ST_BRANCH = 4'd11,
    ST_JUMP   = 4'd12
  } state_e;

  // Unqualified per-state control word; done marks a state that can end an instruction.
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       ir_write;
    logic       reg_write;
    logic       reg_dst;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic [1:0] alu_op;
    logic       done;
  } ctrl_t;

  function automatic logic op_is_legal(input logic [5:0] op);
    logic legal;
    case (op)
      OP_RTYPE, OP_LW, OP_SW, OP_ADDI, OP_BEQ, OP_J: legal = 1'b1;
      default:                                       legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/mc_out_decode.sv
// Pure combinational map from controller state to the unqualified
// datapath control word.
module mc_out_decode
  import mips_ctrl_pkg::*;
(
  input  state_e state,
  output ctrl_t  ctrl
);

  // State-to-control-word table; anything not set stays 0.
  always_comb begin
    ctrl = '0;
    case (state)
      ST_INIT: begin
        ctrl = '0;
      end
      ST_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.ir_write  = 1'b1;
        ctrl.pc_write  = 1'b1;
        ctrl.alu_src_b = ALUSRCB_FOUR;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.pc_src    = PCSRC_ALU;
      end
      ST_DECODE: begin
        ctrl.alu_src_b = ALUSRCB_IMM_SH2;
        ctrl.alu_op    = ALUOP_ADD;
      end
      ST_MEMADR, ST_ADDIEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = ALUSRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      ST_MEMRD: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
      end
      ST_MEMWR: begin
        ctrl.mem_write = 1'b1;
        ctrl.iord      = 1'b1;
        ctrl.done      = 1'b1;
      end
      ST_MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.done       = 1'b1;
      end
      ST_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = ALUSRCB_B;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      ST_ALUWB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
        ctrl.done      = 1'b1;
      end
      ST_ADDIWB: begin
        ctrl.reg_write = 1'b1;
        ctrl.done      = 1'b1;
      end
      ST_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_op        = ALUOP_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_src        = PCSRC_ALUOUT;
        ctrl.done          = 1'b1;
      end
      ST_JUMP: begin
        ctrl.pc_write = 1'b1;
        ctrl.pc_src   = PCSRC_JUMP;
        ctrl.done     = 1'b1;
      end
      default: begin
        ctrl = '0;
      end
    endcase
  end

endmodule

// File: rtl/mc_main_ctrl.sv
// Multicycle MIPS main control FSM: state register, next-state logic and the
// mem_ready / illegal-opcode qualifiers on top of the per-state control word.
module mc_main_ctrl
  import mips_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] ir_op,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       mem_to_reg,
  output logic       ir_write,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_src,
  output logic [1:0] alu_op,
  output logic       illegal,
  output logic       instr_done
);

  state_e state_r;
  state_e next_state_s;
  ctrl_t  ctrl_s;
  logic   legal_s;

  assign legal_s = op_is_legal(ir_op);

  mc_out_decode u_out_decode (
    .state (state_r),
    .ctrl  (ctrl_s)
  );

  // State register; outputs are decoded from it, so reset clears them at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_INIT;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_INIT:   next_state_s = ST_FETCH;
      ST_FETCH: begin
        if (mem_ready) next_state_s = ST_DECODE;
        else           next_state_s = ST_FETCH;
      end
      ST_DECODE: begin
        case (ir_op)
          OP_RTYPE:     next_state_s = ST_EXEC;
          OP_LW, OP_SW: next_state_s = ST_MEMADR;
          OP_ADDI:      next_state_s = ST_ADDIEX;
          OP_BEQ:       next_state_s = ST_BRANCH;
          OP_J:         next_state_s = ST_JUMP;
          default:      next_state_s = ST_FETCH;
        endcase
      end
      ST_MEMADR: begin
        if (ir_op == OP_LW) next_state_s = ST_MEMRD;
        else                next_state_s = ST_MEMWR;
      end
      ST_MEMRD: begin
        if (mem_ready) next_state_s = ST_MEMWB;
        else           next_state_s = ST_MEMRD;
      end
      ST_MEMWR: begin
        if (mem_ready) next_state_s = ST_FETCH;
        else           next_state_s = ST_MEMWR;
      end
      ST_EXEC:   next_state_s = ST_ALUWB;
      ST_ADDIEX: next_state_s = ST_ADDIWB;
      ST_MEMWB, ST_ALUWB, ST_ADDIWB, ST_BRANCH, ST_JUMP: next_state_s = ST_FETCH;
      default:   next_state_s = ST_INIT;
    endcase
  end

  // Output qualification: FETCH updates and MEMWR completion wait for memory.
  always_comb begin
    pc_write      = ctrl_s.pc_write;
    pc_write_cond = ctrl_s.pc_write_cond;
    iord          = ctrl_s.iord;
    mem_read      = ctrl_s.mem_read;
    mem_write     = ctrl_s.mem_write;
    mem_to_reg    = ctrl_s.mem_to_reg;
    ir_write      = ctrl_s.ir_write;
    reg_write     = ctrl_s.reg_write;
    reg_dst       = ctrl_s.reg_dst;
    alu_src_a     = ctrl_s.alu_src_a;
    alu_src_b     = ctrl_s.alu_src_b;
    pc_src        = ctrl_s.pc_src;
    alu_op        = ctrl_s.alu_op;
    illegal       = 1'b0;
    instr_done    = ctrl_s.done;
    if (state_r == ST_FETCH) begin
      pc_write = ctrl_s.pc_write & mem_ready;
      ir_write = ctrl_s.ir_write & mem_ready;
    end else if (state_r == ST_MEMWR) begin
      instr_done = ctrl_s.done & mem_ready;
    end else if (state_r == ST_DECODE) begin
      illegal    = ~legal_s;
      instr_done = ~legal_s;
    end else begin
      illegal    = 1'b0;
    end
  end

endmodule
